// File: rtl/titan_mem_access_unit.sv
// MEM-stage load/store unit: one data-bus transaction per load/store, lane steering, load extension.
// Latency >= 3 cycles (IDLE, WAIT, DONE); stalls the pipeline while the bus holds off ready/error.
module titan_mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    input  logic [5:0]  mem_mem_flags,
    input  logic        flush,
    output logic [31:0] dport_address,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_sel,
    output logic        dport_wr,
    output logic        dport_enable,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ready,
    input  logic        dport_error,
    output logic [31:0] mem_load_data,
    output logic        mem_stall,
    output logic        exc_load_misaligned,
    output logic        exc_store_misaligned,
    output logic        exc_load_fault,
    output logic        exc_store_fault,
    output logic [31:0] exc_bad_addr
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_nxt;
    logic          timeout_hit;
    logic          byte_q, half_q, uns_q, fault_q;
    logic [1:0]    lane_q;

    logic f_read, f_write, f_byte, f_half, f_word, f_uns;
    logic size_ok, req, misaligned, issue, bus_done, done_fault;
    logic [1:0]  lane;
    logic [3:0]  sel_n;
    logic [31:0] data_n;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign {f_read, f_write, f_byte, f_half, f_word, f_uns} = mem_mem_flags;

    assign size_ok    = (f_byte & ~f_half & ~f_word) | (~f_byte & f_half & ~f_word) |
                        (~f_byte & ~f_half & f_word);
    // Reset also masks the combinational request so stall/exceptions read 0 while rst is low.
    assign req        = rst & (f_read | f_write) & size_ok & ~flush;
    assign misaligned = (f_half & mem_addr[0]) | (f_word & (mem_addr[1:0] != 2'b00));
    assign issue      = (state == IDLE) & req & ~misaligned;
    assign lane       = mem_addr[1:0];
    assign bus_done   = dport_ready | dport_error;

    assign cnt_nxt     = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT != 0) && (cnt_nxt == (CW+1)'(TIMEOUT));

    always_comb begin
        sel_n  = 4'b1111;
        data_n = mem_store_data;
        if (f_byte) begin
            sel_n  = 4'b0001 << lane;
            data_n = {4{mem_store_data[7:0]}};
        end else if (f_half) begin
            sel_n  = 4'b0011 << lane;
            data_n = {2{mem_store_data[15:0]}};
        end
    end

    assign ld_byte = dport_data_i[{lane_q, 3'b000} +: 8];
    assign ld_half = dport_data_i[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dport_data_i;
        if (byte_q)
            load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
        else if (half_q)
            load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            dport_address <= '0;
            dport_data_o  <= '0;
            dport_sel     <= '0;
            dport_wr      <= 1'b0;
            dport_enable  <= 1'b0;
            mem_load_data <= '0;
            byte_q        <= 1'b0;
            half_q        <= 1'b0;
            uns_q         <= 1'b0;
            lane_q        <= '0;
            fault_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state         <= WAIT;
                        cnt           <= '0;
                        dport_address <= {mem_addr[31:2], 2'b00};
                        dport_data_o  <= data_n;
                        dport_sel     <= sel_n;
                        dport_wr      <= f_write;
                        dport_enable  <= 1'b1;
                        byte_q        <= f_byte;
                        half_q        <= f_half;
                        uns_q         <= f_uns;
                        lane_q        <= lane;
                        fault_q       <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt[CW-1:0];
                    if (bus_done) begin
                        state        <= DONE;
                        dport_enable <= 1'b0;
                        fault_q      <= dport_error;
                        if (!dport_error && !dport_wr)
                            mem_load_data <= load_ext;
                    end else if (flush) begin
                        state <= DRAIN;
                    end else if (timeout_hit) begin
                        state        <= DONE;
                        dport_enable <= 1'b0;
                        fault_q      <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    fault_q <= 1'b0;
                end
                DRAIN: begin
                    // The bus cycle must still complete; its result is thrown away.
                    if (bus_done) begin
                        state        <= IDLE;
                        dport_enable <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done_fault           = (state == DONE) & fault_q & ~flush;
    assign exc_load_fault       = done_fault & ~dport_wr;
    assign exc_store_fault      = done_fault & dport_wr;
    assign exc_load_misaligned  = (state == IDLE) & req & misaligned & ~f_write;
    assign exc_store_misaligned = (state == IDLE) & req & misaligned & f_write;
    assign exc_bad_addr         = (exc_load_fault | exc_store_fault | exc_load_misaligned |
                                   exc_store_misaligned) ? mem_addr : 32'h0;
    assign mem_stall            = issue | (state == WAIT) | (state == DRAIN);

endmodule

// File: tb/tb_titan_mem_access_unit.sv
// Directed bench for titan_mem_access_unit: bus handshake, steering, exceptions, flush and reset.
module tb_titan_mem_access_unit;

    localparam logic [5:0] RD  = 6'b100000;
    localparam logic [5:0] WR  = 6'b010000;
    localparam logic [5:0] BY  = 6'b001000;
    localparam logic [5:0] HW  = 6'b000100;
    localparam logic [5:0] WD  = 6'b000010;
    localparam logic [5:0] UNS = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic [5:0]  mem_mem_flags;
    logic        flush;
    logic [31:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_sel;
    logic        dport_wr;
    logic        dport_enable;
    logic [31:0] dport_data_i;
    logic        dport_ready;
    logic        dport_error;
    logic [31:0] mem_load_data;
    logic        mem_stall;
    logic        exc_load_misaligned;
    logic        exc_store_misaligned;
    logic        exc_load_fault;
    logic        exc_store_fault;
    logic [31:0] exc_bad_addr;

    int n_assert = 0;
    int n_fail   = 0;

    titan_mem_access_unit #(.TIMEOUT(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_addr             (mem_addr),
        .mem_store_data       (mem_store_data),
        .mem_mem_flags        (mem_mem_flags),
        .flush                (flush),
        .dport_address        (dport_address),
        .dport_data_o         (dport_data_o),
        .dport_sel            (dport_sel),
        .dport_wr             (dport_wr),
        .dport_enable         (dport_enable),
        .dport_data_i         (dport_data_i),
        .dport_ready          (dport_ready),
        .dport_error          (dport_error),
        .mem_load_data        (mem_load_data),
        .mem_stall            (mem_stall),
        .exc_load_misaligned  (exc_load_misaligned),
        .exc_store_misaligned (exc_store_misaligned),
        .exc_load_fault       (exc_load_fault),
        .exc_store_fault      (exc_store_fault),
        .exc_bad_addr         (exc_bad_addr)
    );

    initial forever #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load with ready on the first WAIT cycle; checks the result in DONE.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [5:0] f,
                           input logic [31:0] rd, input logic [31:0] exp);
        cyc(); mem_addr = a; mem_mem_flags = f;
        cyc(); dport_ready = 1'b1; dport_data_i = rd;
        cyc(); dport_ready = 1'b0;
        #1 chk(tag, mem_load_data, exp);
    endtask

    initial begin
        rst = 1'b0; mem_addr = '0; mem_store_data = '0; mem_mem_flags = '0; flush = 1'b0;
        dport_data_i = '0; dport_ready = 1'b0; dport_error = 1'b0;

        repeat (3) cyc();
        #1;
        chk("rst_enable", {31'b0, dport_enable}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_load_data", mem_load_data, 32'h0);
        chk("rst_sel", {28'b0, dport_sel}, 32'h0);
        cyc(); rst = 1'b1;

        // lw 0x100, ready on third WAIT cycle
        cyc(); mem_addr = 32'h100; mem_mem_flags = RD | WD;
        #1 chk("lw_idle_stall", {31'b0, mem_stall}, 32'd1);
        chk("lw_idle_enable", {31'b0, dport_enable}, 32'd0);
        cyc();
        #1 chk("lw_enable", {31'b0, dport_enable}, 32'd1);
        chk("lw_address", dport_address, 32'h100);
        chk("lw_sel", {28'b0, dport_sel}, 32'hF);
        chk("lw_wr", {31'b0, dport_wr}, 32'd0);
        chk("lw_w1_stall", {31'b0, mem_stall}, 32'd1);
        cyc();
        #1 chk("lw_w2_stall", {31'b0, mem_stall}, 32'd1);
        cyc(); dport_ready = 1'b1; dport_data_i = 32'hDEADBEEF;
        #1 chk("lw_w3_stall", {31'b0, mem_stall}, 32'd1);
        cyc(); dport_ready = 1'b0;
        #1 chk("lw_done_stall", {31'b0, mem_stall}, 32'd0);
        chk("lw_load_data", mem_load_data, 32'hDEADBEEF);
        chk("lw_done_enable", {31'b0, dport_enable}, 32'd0);
        chk("lw_no_fault", {31'b0, exc_load_fault}, 32'd0);

        // byte/half steering and extension
        do_load("lb_0x103", 32'h103, RD | BY, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu_0x103", 32'h103, RD | BY | UNS, 32'h80112233, 32'h00000080);
        do_load("lh_0x102", 32'h102, RD | HW, 32'h80112233, 32'hFFFF8011);
        do_load("lbu_0x101", 32'h101, RD | BY | UNS, 32'h80112233, 32'h00000022);
        do_load("lh_0x102b", 32'h102, RD | HW, 32'h80112233, 32'hFFFF8011);

        // sh 0x102
        cyc(); mem_addr = 32'h102; mem_mem_flags = WR | HW; mem_store_data = 32'h1234ABCD;
        cyc();
        #1 chk("sh_data_o", dport_data_o, 32'hABCDABCD);
        chk("sh_sel", {28'b0, dport_sel}, 32'hC);
        chk("sh_wr", {31'b0, dport_wr}, 32'd1);
        chk("sh_address", dport_address, 32'h100);
        dport_ready = 1'b1;
        cyc(); dport_ready = 1'b0;
        #1 chk("sh_no_fault", {31'b0, exc_store_fault}, 32'd0);
        chk("sh_no_misalign", {31'b0, exc_store_misaligned}, 32'd0);

        // lw 0x102 misaligned
        cyc(); mem_addr = 32'h102; mem_mem_flags = RD | WD;
        #1 chk("lw_mis_exc", {31'b0, exc_load_misaligned}, 32'd1);
        chk("lw_mis_bad_addr", exc_bad_addr, 32'h102);
        chk("lw_mis_stall", {31'b0, mem_stall}, 32'd0);
        cyc(); mem_mem_flags = '0;
        #1 chk("lw_mis_enable", {31'b0, dport_enable}, 32'd0);

        // sw 0x200 with bus error
        cyc(); mem_addr = 32'h200; mem_mem_flags = WR | WD; mem_store_data = 32'h55AA55AA;
        cyc(); dport_error = 1'b1;
        #1 chk("sw_err_wait_exc", {31'b0, exc_store_fault}, 32'd0);
        cyc(); dport_error = 1'b0;
        #1 chk("sw_err_done_exc", {31'b0, exc_store_fault}, 32'd1);
        chk("sw_err_bad_addr", exc_bad_addr, 32'h200);
        chk("sw_err_no_loadexc", {31'b0, exc_load_fault}, 32'd0);
        cyc(); mem_mem_flags = '0;
        #1 chk("sw_err_after", {31'b0, exc_store_fault}, 32'd0);

        // lw 0x300 with no response: timeout after 4 WAIT cycles
        cyc(); mem_addr = 32'h300; mem_mem_flags = RD | WD;
        repeat (4) cyc();
        #1 chk("to_w4_exc", {31'b0, exc_load_fault}, 32'd0);
        chk("to_w4_enable", {31'b0, dport_enable}, 32'd1);
        cyc();
        #1 chk("to_done_exc", {31'b0, exc_load_fault}, 32'd1);
        chk("to_done_enable", {31'b0, dport_enable}, 32'd0);
        chk("to_bad_addr", exc_bad_addr, 32'h300);
        chk("to_load_data", mem_load_data, 32'hFFFF8011);

        // flush during load WAIT -> DRAIN
        cyc(); mem_addr = 32'h104; mem_mem_flags = RD | WD; dport_data_i = 32'h11111111;
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;
        #1 chk("drain_enable", {31'b0, dport_enable}, 32'd1);
        chk("drain_stall", {31'b0, mem_stall}, 32'd1);
        cyc(); dport_ready = 1'b1;
        #1 chk("drain_ready_stall", {31'b0, mem_stall}, 32'd1);
        chk("drain_no_exc", {31'b0, exc_load_fault}, 32'd0);
        cyc(); dport_ready = 1'b0; mem_mem_flags = '0;
        #1 chk("drain_exit_enable", {31'b0, dport_enable}, 32'd0);
        chk("drain_exit_stall", {31'b0, mem_stall}, 32'd0);
        chk("drain_load_kept", mem_load_data, 32'hFFFF8011);

        // reset during WAIT
        cyc(); mem_addr = 32'h108; mem_mem_flags = RD | WD;
        cyc(); rst = 1'b0;
        #1 chk("rstw_wait_enable", {31'b0, dport_enable}, 32'd1);
        cyc(); rst = 1'b1; mem_mem_flags = '0;
        #1 chk("rstw_enable", {31'b0, dport_enable}, 32'd0);
        chk("rstw_stall", {31'b0, mem_stall}, 32'd0);
        chk("rstw_load_data", mem_load_data, 32'h0);
        cyc();
        #1 chk("rstw_idle_enable", {31'b0, dport_enable}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
